// File: rtl/elevator_request_panel.sv
// Hall and car request latching for a 4-floor elevator: synchronises raw button
// presses, holds requests until the car services them, and flags long-unserviced requests.
module elevator_request_panel #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] press_up,
  input  logic [2:0] press_down,
  input  logic [3:0] press_in,
  input  logic       clear_all,
  input  logic [2:0] position,
  input  logic       open,
  input  logic [1:0] direction,
  output logic [2:0] button_up,
  output logic [2:0] button_down,
  output logic [3:0] button_in,
  output logic [3:0] pending_count,
  output logic       stuck
);

  localparam int unsigned N_REQ = 10;
  localparam int unsigned CNT_W = 16;

  // Request vector layout: [2:0] hall up, [5:3] hall down (floors 1..3), [9:6] car
  logic [N_REQ-1:0] press_raw;
  logic [N_REQ-1:0] sync1_q, sync2_q, sync3_q;
  logic [N_REQ-1:0] press_ev;
  logic [N_REQ-1:0] req_q, req_d;
  logic [N_REQ-1:0] clr_mask;
  logic [3:0]       at_floor;
  logic             service;
  logic             any_cleared;
  logic             wait_rst;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W:0]   wait_diff;
  logic             stuck_d;

  assign press_raw = {press_in, press_down, press_up};
  assign press_ev  = sync2_q & ~sync3_q;

  // Which request bits the car is servicing this cycle
  always_comb begin
    service  = open && (position <= 3'd3);
    at_floor = '0;
    if (service) at_floor = 4'b0001 << position[1:0];
    clr_mask = {at_floor,
                at_floor[3:1] & {3{direction != 2'b01}},
                at_floor[2:0] & {3{direction != 2'b10}}};
  end

  // Clear beats set; clear_all beats everything
  always_comb begin
    req_d       = (req_q | press_ev) & ~clr_mask;
    any_cleared = |(req_q & clr_mask);
    if (clear_all) req_d = '0;
  end

  assign pending_count = 4'($countones(req_q));

  // Service watchdog: counts cycles with pending requests and no service
  always_comb begin
    wait_rst  = (pending_count == 4'd0) || clear_all || any_cleared;
    wait_d    = wait_q;
    if (wait_rst)                 wait_d = '0;
    else if (wait_q != 16'hFFFF)  wait_d = wait_q + 16'd1;
    wait_diff = {1'b0, wait_d} - {1'b0, TIMEOUT};
    stuck_d   = !wait_rst && !wait_diff[CNT_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      req_q   <= '0;
      wait_q  <= '0;
      stuck   <= 1'b0;
    end else begin
      sync1_q <= press_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      req_q   <= req_d;
      wait_q  <= wait_d;
      stuck   <= stuck_d;
    end
  end

  assign button_up   = req_q[2:0];
  assign button_down = req_q[5:3];
  assign button_in   = req_q[9:6];

endmodule

// File: tb/tb_elevator_request_panel.sv
// Directed plus randomized bench for elevator_request_panel, checked against a
// cycle-level behavioural model of the request panel.
module tb_elevator_request_panel;

  logic       clk;
  logic       reset_n;
  logic [2:0] press_up, press_down;
  logic [3:0] press_in;
  logic       clear_all;
  logic [2:0] position;
  logic       open;
  logic [1:0] direction;
  logic [2:0] button_up, button_down, button_up0, button_down0;
  logic [3:0] button_in, pending_count, button_in0, pending_count0;
  logic       stuck, stuck0;

  int n_pass = 0;
  int n_total = 0;

  elevator_request_panel #(.TIMEOUT(16'd4)) dut (
    .clk(clk), .reset_n(reset_n), .press_up(press_up), .press_down(press_down),
    .press_in(press_in), .clear_all(clear_all), .position(position), .open(open),
    .direction(direction), .button_up(button_up), .button_down(button_down),
    .button_in(button_in), .pending_count(pending_count), .stuck(stuck));

  elevator_request_panel #(.TIMEOUT(16'd0)) dut0 (
    .clk(clk), .reset_n(reset_n), .press_up(press_up), .press_down(press_down),
    .press_in(press_in), .clear_all(clear_all), .position(position), .open(open),
    .direction(direction), .button_up(button_up0), .button_down(button_down0),
    .button_in(button_in0), .pending_count(pending_count0), .stuck(stuck0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [9:0] hist[$];
  logic [9:0] m_req;
  int         m_wait;
  bit         m_stuck, m_stuck0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    m_req = '0;
    m_wait = 0;
    m_stuck = 0;
    m_stuck0 = 0;
  endtask

  // Is request bit i served by the car in its present state?
  function automatic bit served(int i);
    int floor_i;
    if (!(open && position <= 3)) return 0;
    if (i < 3) begin
      floor_i = i;
      return (position == floor_i) && (direction != 2'b10);
    end else if (i < 6) begin
      floor_i = i - 2;
      return (position == floor_i) && (direction != 2'b01);
    end
    floor_i = i - 6;
    return position == floor_i;
  endfunction

  // One rising edge: a press sampled two edges ago that was low three edges ago sets its bit now
  task automatic model_edge();
    logic [9:0] older, oldest, nxt;
    int n, pend;
    bit cleared;
    hist.push_back({press_in, press_down, press_up});
    n = hist.size();
    older  = (n >= 3) ? hist[n-3] : 10'd0;
    oldest = (n >= 4) ? hist[n-4] : 10'd0;
    if (n > 4) void'(hist.pop_front());
    pend = $countones(m_req);
    cleared = 0;
    for (int i = 0; i < 10; i++) begin
      if (clear_all) nxt[i] = 1'b0;
      else if (served(i)) begin
        if (m_req[i]) cleared = 1;
        nxt[i] = 1'b0;
      end else nxt[i] = m_req[i] | (older[i] & ~oldest[i]);
    end
    if (pend == 0 || clear_all || cleared) begin
      m_wait = 0;
      m_stuck = 0;
      m_stuck0 = 0;
    end else begin
      m_wait = (m_wait < 65535) ? m_wait + 1 : 65535;
      m_stuck = (m_wait >= 4);
      m_stuck0 = 1;
    end
    m_req = nxt;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".up"},      16'(button_up),     16'(m_req[2:0]));
    check({tag, ".down"},    16'(button_down),   16'(m_req[5:3]));
    check({tag, ".in"},      16'(button_in),     16'(m_req[9:6]));
    check({tag, ".count"},   16'(pending_count), 16'($countones(m_req)));
    check({tag, ".stuck"},   16'(stuck),         16'(m_stuck));
    check({tag, ".stuck0"},  16'(stuck0),        16'(m_stuck0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  int stuck_at;

  initial begin
    reset_n = 1'b0; press_up = '0; press_down = '0; press_in = '0;
    clear_all = 1'b0; position = 3'd0; open = 1'b0; direction = 2'b00;
    model_reset();
    #3;
    compare_all("reset");
    #9 reset_n = 1'b1;

    // Single hall-up press at floor 0, door closed
    press_up = 3'b001;
    step("p31a");
    press_up = 3'b000;
    step("p31b");
    check("p31_not_yet", 16'(button_up), 16'h0);
    step("p31c");
    check("p31_up", 16'(button_up), 16'h1);
    check("p31_cnt", 16'(pending_count), 16'h1);
    clear_all = 1'b1; step("p31clr"); clear_all = 1'b0;

    // Car request for floor 2 serviced by door opening there
    press_in = 4'b0100; step("p32a"); press_in = '0;
    step("p32b"); step("p32c");
    check("p32_set", 16'(button_in), 16'h4);
    position = 3'd2; open = 1'b1; direction = 2'b00;
    step("p32d");
    check("p32_clr", 16'(button_in), 16'h0);
    check("p32_cnt", 16'(pending_count), 16'h0);
    open = 1'b0;

    // Floor 1 up and down requests; car going up only clears the up request
    position = 3'd1;
    press_up = 3'b010; press_down = 3'b001; step("p33a");
    press_up = '0; press_down = '0;
    step("p33b"); step("p33c");
    check("p33_up_set", 16'(button_up), 16'h2);
    check("p33_dn_set", 16'(button_down), 16'h1);
    open = 1'b1; direction = 2'b01;
    step("p33d");
    check("p33_up_clr", 16'(button_up), 16'h0);
    check("p33_dn_keep", 16'(button_down), 16'h1);
    open = 1'b0; direction = 2'b00;
    clear_all = 1'b1; step("p33clr"); clear_all = 1'b0;

    // Press at the floor where the door is open never latches
    position = 3'd0; open = 1'b1;
    press_in = 4'b0001; step("p34a"); press_in = '0;
    for (int i = 0; i < 5; i++) step("p34b");
    check("p34_never", 16'(button_in), 16'h0);
    open = 1'b0;

    // Watchdog with TIMEOUT=4, then clear_all
    press_in = 4'b1000; step("p35a"); press_in = '0;
    step("p35b"); step("p35c");
    check("p35_set", 16'(button_in), 16'h8);
    stuck_at = -1;
    for (int i = 1; i <= 20 && stuck_at < 0; i++) begin
      step("p35w");
      if (stuck === 1'b1) stuck_at = i;
    end
    check("p35_stuck_cycles", 16'(stuck_at), 16'd4);
    clear_all = 1'b1; step("p35clr"); clear_all = 1'b0;
    check("p35_in0", 16'(button_in), 16'h0);
    check("p35_stuck0", 16'(stuck), 16'h0);

    // Asynchronous reset mid-cycle with a press held across release
    press_up = 3'b100; step("p36a"); step("p36b"); step("p36c");
    press_in = 4'b1000;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("p36rst");
    check("p36_up_async", 16'(button_up), 16'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    press_up = '0;
    step("p36e1");
    check("p36_e1", 16'(button_in), 16'h0);
    step("p36e2");
    check("p36_e2", 16'(button_in), 16'h0);
    step("p36e3");
    check("p36_e3", 16'(button_in), 16'h8);
    for (int i = 0; i < 6; i++) step("p36hold");
    press_in = '0;
    check("p36_once_cnt", 16'(pending_count), 16'h1);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      press_up   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
      press_down = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
      press_in   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      position   = 3'($urandom_range(0, 7));
      open       = ($urandom_range(0, 3) == 0);
      direction  = 2'($urandom);
      clear_all  = ($urandom_range(0, 60) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
